// File: rtl/mdiv_host_seq.sv
// Host-side sequencer for the 256-bit modular inverse/division core: loads p/a/b
// word-serially, starts the core, waits for done, then drains the result words.
module mdiv_host_seq #(
   parameter int DW      = 32,
   parameter int NW      = 8,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_mode,
   input  logic [DW*NW-1:0] req_p,
   input  logic [DW*NW-1:0] req_a,
   input  logic [DW*NW-1:0] req_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DW*NW-1:0] res_data,
   output logic             res_err,
   output logic             busy,
   output logic [DW-1:0]    datain,
   output logic             loadp,
   output logic             loada,
   output logic             loadb,
   output logic             minv_mdiv,
   output logic             minv_mdiv_en,
   input  logic             minv_mdiv_rdy,
   input  logic [DW-1:0]    result_out,
   input  logic             out_valid,
   output logic             out_ready
);

   localparam int CW = (NW > 1) ? $clog2(NW) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LDP, S_LDA, S_LDB, S_START, S_WAIT, S_READ, S_RESP
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [TW-1:0]    tcnt;
   logic [DW*NW-1:0] p_q, a_q, b_q;
   logic             mode_q;
   logic             last_word, rdy_ok, tmo_hit;

   assign last_word = (cnt == CW'(NW - 1));
   // the first WAIT cycle (tcnt==0) still sees the core's stale done flag
   assign rdy_ok    = minv_mdiv_rdy && (tcnt != '0);
   assign tmo_hit   = (tcnt == TW'(TIMEOUT - 1));
   assign minv_mdiv = mode_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_ready    = 1'b0;
      busy         = 1'b1;
      loadp        = 1'b0;
      loada        = 1'b0;
      loadb        = 1'b0;
      datain       = '0;
      minv_mdiv_en = 1'b0;
      out_ready    = 1'b0;
      res_valid    = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nxt = S_LDP;
         end
         S_LDP: begin
            loadp  = 1'b1;
            datain = p_q[cnt*DW +: DW];
            if (last_word) state_nxt = S_LDA;
         end
         S_LDA: begin
            loada  = 1'b1;
            datain = a_q[cnt*DW +: DW];
            if (last_word) state_nxt = mode_q ? S_START : S_LDB;
         end
         S_LDB: begin
            loadb  = 1'b1;
            datain = b_q[cnt*DW +: DW];
            if (last_word) state_nxt = S_START;
         end
         S_START: begin
            minv_mdiv_en = 1'b1;
            state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            if (rdy_ok)       state_nxt = S_READ;
            else if (tmo_hit) state_nxt = S_RESP;
         end
         S_READ: begin
            out_ready = 1'b1;
            if (out_valid && last_word) state_nxt = S_RESP;
         end
         S_RESP: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         tcnt     <= '0;
         p_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= 1'b0;
         res_data <= '0;
         res_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               p_q      <= req_p;
               a_q      <= req_a;
               b_q      <= req_b;
               mode_q   <= req_mode;
               res_data <= '0;
               res_err  <= 1'b0;
            end
            S_LDP, S_LDA, S_LDB: cnt <= last_word ? '0 : cnt + 1'b1;
            S_START: tcnt <= '0;
            S_WAIT: begin
               tcnt <= tcnt + 1'b1;
               if (!rdy_ok && tmo_hit) begin
                  res_err  <= 1'b1;
                  res_data <= '0;
               end
            end
            S_READ: if (out_valid) begin
               res_data[cnt*DW +: DW] <= result_out;
               cnt <= last_word ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdiv_host_seq.sv
// Randomized scoreboard bench for mdiv_host_seq with a behavioural core model that
// rebuilds operands from the load strobes and serves results with configurable timing.
module tb_mdiv_host_seq;
   localparam int DW = 32, NW = 8, TMO = 24;

   logic clk, rst;
   logic req_valid, req_ready, req_mode;
   logic [255:0] req_p, req_a, req_b, res_data;
   logic res_valid, res_ready, res_err, busy;
   logic [31:0] datain, result_out;
   logic loadp, loada, loadb, minv_mdiv, minv_mdiv_en, minv_mdiv_rdy, out_valid, out_ready;

   mdiv_host_seq #(.DW(DW), .NW(NW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_mode(req_mode), .req_p(req_p), .req_a(req_a), .req_b(req_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .busy(busy), .datain(datain), .loadp(loadp),
      .loada(loada), .loadb(loadb), .minv_mdiv(minv_mdiv),
      .minv_mdiv_en(minv_mdiv_en), .minv_mdiv_rdy(minv_mdiv_rdy),
      .result_out(result_out), .out_valid(out_valid), .out_ready(out_ready));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   int checks = 0, failures = 0;
   logic [256:0] exp_q[$];

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Core behaviour: small operands get real modular arithmetic, wide operands a
   // position-sensitive scramble so any word misordering shows up in the result.
   function automatic logic [255:0] core_fn(input logic [255:0] p, a, b, input logic m);
      logic [255:0] r;
      longint pp, av, tgt;
      r = '0;
      if (p[255:32] == 0 && a[255:32] == 0 && (m || b[255:32] == 0)) begin
         pp  = longint'(p[31:0]);
         av  = longint'(a[31:0]) % pp;
         tgt = m ? 1 : longint'(b[31:0]) % pp;
         for (longint x = 0; x < pp; x++)
            if ((av * x) % pp == tgt) begin
               r[31:0] = x[31:0];
               break;
            end
      end else begin
         for (int k = 0; k < NW; k++) begin
            logic [31:0] aw;
            aw = a[(NW-1-k)*32 +: 32];
            r[k*32 +: 32] = (p[k*32 +: 32] ^ {aw[15:0], aw[31:16]}) + (m ? 32'h0 : b[k*32 +: 32]);
         end
      end
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // core model configuration, written only by the stimulus process
   logic c_stale = 0, c_toggle = 0, c_noreply = 0;
   int   c_delay = 4, stall_cfg = 0;

   logic [255:0] p_cap = '0, a_cap = '0, b_cap = '0;
   int np = 0, na = 0, nb = 0, nen = 0, wait_cyc = 0;

   always @(posedge clk) begin
      if (loadp) begin p_cap <= {datain, p_cap[255:32]}; np <= np + 1; end
      if (loada) begin a_cap <= {datain, a_cap[255:32]}; na <= na + 1; end
      if (loadb) begin b_cap <= {datain, b_cap[255:32]}; nb <= nb + 1; end
      if (minv_mdiv_en) nen <= nen + 1;
   end

   initial begin
      logic [255:0] res;
      int n, k, first, guard;
      logic ov;
      minv_mdiv_rdy = 0; out_valid = 0; result_out = 0;
      forever begin
         @(negedge clk);
         if (minv_mdiv_en) begin
            res = core_fn(p_cap, a_cap, b_cap, minv_mdiv);
            n = 0;
            if (c_noreply) begin
               while (!res_valid && n < 200) begin @(negedge clk); n++; end
               wait_cyc = n;
            end else begin
               minv_mdiv_rdy = c_stale;
               while (n < c_delay) begin
                  @(negedge clk); n++;
                  if (n == 2) minv_mdiv_rdy = 0;
               end
               minv_mdiv_rdy = 1;
               k = 0; first = -1; guard = 0; ov = 0;
               while (k < NW && guard < 2000) begin
                  @(negedge clk); n++; guard++;
                  if (out_ready && first < 0) begin first = n; minv_mdiv_rdy = 0; end
                  ov = c_toggle ? !ov : ($urandom_range(0, 3) != 0);
                  out_valid  = ov;
                  result_out = res[k*32 +: 32];
                  if (ov && out_ready) k++;
               end
               wait_cyc = first;
               @(negedge clk);
               out_valid = 0; result_out = 0; minv_mdiv_rdy = 0;
            end
         end
      end
   end

   // response monitor: drives res_ready, pops the scoreboard on each handshake
   int prot_err = 0, nresp = 0, stall_left = 0;
   logic in_resp = 0;
   logic [255:0] prev_data;
   always @(negedge clk) begin
      if (!rst) begin
         if (int'(loadp) + int'(loada) + int'(loadb) > 1) prot_err++;
         if (!(loadp | loada | loadb) && datain != 0) prot_err++;
      end
      if (res_valid && !rst) begin
         if (!in_resp) begin in_resp = 1; stall_left = stall_cfg; prev_data = res_data; end
         if (res_data !== prev_data) prot_err++;
         prev_data = res_data;
         if (stall_left > 0) begin
            res_ready = 0;
            stall_left--;
         end else begin
            res_ready = 1;
            in_resp = 0;
            nresp++;
            if (exp_q.size() == 0) check("unexpected_response", 256'd1, 256'd0);
            else begin
               logic [256:0] e;
               e = exp_q.pop_front();
               check("res_data", res_data, e[255:0]);
               check("res_err", {255'd0, res_err}, {255'd0, e[256]});
            end
         end
      end else begin
         res_ready = 0;
         in_resp = 0;
      end
   end

   task automatic send(input logic [255:0] p, a, b, input logic m,
                       input logic [255:0] ed, input logic ee);
      int n;
      @(negedge clk);
      req_p = p; req_a = a; req_b = b; req_mode = m; req_valid = 1;
      n = 0;
      while (!req_ready && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000) check("accept_timeout", 256'd1, 256'd0);
      exp_q.push_back({ee, ed});
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic send_ref(input logic [255:0] p, a, b, input logic m);
      send(p, a, b, m, core_fn(p, a, b, m), 1'b0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
      if (n >= 3000) check("done_timeout", 256'd1, 256'd0);
   endtask

   initial begin
      int s_np, s_na, s_nb, s_nen, s_resp, n;
      int primes[8] = '{7, 11, 13, 97, 101, 251, 509, 1009};
      logic [255:0] p, a, b;
      logic m;
      rst = 1; req_valid = 0; req_mode = 0; req_p = 0; req_a = 0; req_b = 0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {255'd0, req_ready}, 256'd1);
      check("rst_outs", {248'd0, busy, res_valid, res_err, loadp, loada, loadb,
                         minv_mdiv_en, out_ready}, 256'd0);
      check("rst_datain_mode", {223'd0, minv_mdiv, datain}, 256'd0);
      check("rst_res_data", res_data, 256'd0);
      rst = 0;

      // inverse 2^-1 mod 7
      s_np = np; s_na = na; s_nb = nb; s_nen = nen;
      send(256'd7, 256'd2, 256'd0, 1'b1, 256'd4, 1'b0);
      wait_done();
      check("t1_loads", {np - s_np, na - s_na, nb - s_nb, nen - s_nen}, {32'd8, 32'd8, 32'd0, 32'd1});
      check("t1_p_cap", p_cap, 256'd7);
      check("t1_a_cap", a_cap, 256'd2);

      // division 5/3 mod 11
      s_nb = nb;
      send(256'd11, 256'd3, 256'd5, 1'b0, 256'd9, 1'b0);
      wait_done();
      check("t2_loadb", nb - s_nb, 256'd8);
      check("t2_b_cap", b_cap, 256'd5);

      // stale rdy during first WAIT cycle, real rdy 20 cycles after it drops
      c_stale = 1; c_delay = 22;
      send_ref(rnd256(), rnd256(), rnd256(), 1'b0);
      wait_done();
      check("t3_read_entry", wait_cyc, 256'd23);
      c_stale = 0;

      // toggling out_valid with a 5-cycle response stall
      c_toggle = 1; c_delay = 6; stall_cfg = 5; s_resp = nresp;
      send_ref(rnd256(), rnd256(), rnd256(), 1'b1);
      wait_done();
      check("t4_one_resp", nresp - s_resp, 256'd1);
      c_toggle = 0; stall_cfg = 0;

      // core never finishes
      c_noreply = 1;
      send(rnd256(), rnd256(), rnd256(), 1'b0, 256'd0, 1'b1);
      wait_done();
      check("t5_timeout_lat", wait_cyc, TMO + 1);
      c_noreply = 0;

      // randomized pairs, second request held while the first is in flight
      for (int it = 0; it < 16; it++) begin
         c_delay   = $urandom_range(2, TMO - 2);
         stall_cfg = $urandom_range(0, 3);
         for (int j = 0; j < 2; j++) begin
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
               p = 256'(primes[$urandom_range(0, 7)]);
               a = 256'($urandom_range(1, int'(p[31:0]) - 1));
               b = 256'($urandom_range(0, int'(p[31:0]) - 1));
            end else begin
               p = rnd256(); a = rnd256(); b = rnd256();
            end
            send_ref(p, a, b, m);
         end
         wait_done();
      end

      // async reset in the middle of LDA word 3
      a = rnd256();
      send_ref(rnd256(), a, rnd256(), 1'b0);
      n = 0;
      while (!loada && n < 50) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      check("t6_pre_datain", {224'd0, datain}, {224'd0, a[3*32 +: 32]});
      rst = 1;
      #1;
      check("t6_rst_drop", {220'd0, loada, busy, req_ready, datain}, {220'd0, 1'b0, 1'b0, 1'b1, 32'd0});
      exp_q.delete();
      @(negedge clk);
      rst = 0;
      send(256'd13, 256'd5, 256'd0, 1'b1, 256'd8, 1'b0);
      wait_done();

      check("protocol", prot_err, 256'd0);
      check("queue_empty", exp_q.size(), 256'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
